reg_file: RTL and testbench

MIPS general-purpose register file: 32 × 32-bit registers, two asynchronous read ports and one synchronous write port. Sits directly upstream of the ALU in the execute path. Read port 1 drives the ALU `rega` operand and read port 2 drives the `regb` operand. Write-back of the ALU result (or load data) returns through the write port. A third read-only debug port serves the board display logic.

---
 rtl/mips_pkg.sv | 15 +
 rtl/reg_file.sv | 55 +++++
 tb/tb_reg_file.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Constants shared by the MIPS datapath (register file, ALU, control unit).
// Address-typed constants are sized to compare cleanly against register addresses.
package mips_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;

   typedef logic [DATA_W-1:0]     word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file.sv
// MIPS register file: 31 stored registers (r0 reads as zero), two combinational operand
// read ports, one debug read port, one write port committed on the rising clk edge.
module reg_file
   import mips_pkg::*;
#(
   parameter logic [31:0] SP_INIT = 32'h0000_0000,
   parameter bit          BYPASS  = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   input  logic [4:0]  rd_addr,
   input  logic        write_en,
   input  logic [31:0] write_data,
   output logic [31:0] read_data1,
   output logic [31:0] read_data2,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   word_t regs [1:NUM_REGS-1];

   word_t stored1;
   word_t stored2;

   // r0 has no storage; r29 comes out of reset holding the initial stack pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
         end
      end else if (write_en && (rd_addr != REG_ZERO)) begin
         regs[rd_addr] <= write_data;
      end
   end

   assign stored1  = (rs_addr  == REG_ZERO) ? '0 : regs[rs_addr];
   assign stored2  = (rt_addr  == REG_ZERO) ? '0 : regs[rt_addr];
   assign dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs[dbg_addr];

   // Forwarding would close rs -> ALU -> write_data into a loop in the single-cycle core.
   generate
      if (BYPASS) begin : g_bypass
         logic fwd_ok;
         assign fwd_ok     = rst_n && write_en && (rd_addr != REG_ZERO);
         assign read_data1 = (fwd_ok && (rd_addr == rs_addr)) ? write_data : stored1;
         assign read_data2 = (fwd_ok && (rd_addr == rt_addr)) ? write_data : stored2;
      end else begin : g_no_bypass
         assign read_data1 = stored1;
         assign read_data2 = stored2;
      end
   endgenerate

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a non-forwarding and a forwarding instance share stimulus;
// expectations are queued by the stimulus and compared by a monitor on the falling edge.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs_addr, rt_addr, rd_addr, dbg_addr;
   logic        write_en;
   logic [31:0] write_data;
   logic [31:0] a_rd1, a_rd2, a_dbg;
   logic [31:0] b_rd1, b_rd2, b_dbg;

   localparam logic [31:0] SP_VAL = 32'h0000_3FFC;

   reg_file #(.SP_INIT(SP_VAL), .BYPASS(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .write_en(write_en), .write_data(write_data), .read_data1(a_rd1), .read_data2(a_rd2),
      .dbg_addr(dbg_addr), .dbg_data(a_dbg)
   );

   reg_file #(.SP_INIT(SP_VAL), .BYPASS(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .write_en(write_en), .write_data(write_data), .read_data1(b_rd1), .read_data2(b_rd2),
      .dbg_addr(dbg_addr), .dbg_data(b_dbg)
   );

   always #5 clk = ~clk;

   typedef enum int {A_RD1, A_RD2, A_DBG, B_RD1, B_RD2, B_DBG} sel_t;
   typedef struct {
      string       name;
      sel_t        sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        sbq[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] model [32];

   function automatic logic [31:0] pick(sel_t s);
      case (s)
         A_RD1:   return a_rd1;
         A_RD2:   return a_rd2;
         A_DBG:   return a_dbg;
         B_RD1:   return b_rd1;
         B_RD2:   return b_rd2;
         default: return b_dbg;
      endcase
   endfunction

   exp_t        cur;
   logic [31:0] act;
   always @(negedge clk) begin
      while (sbq.size() != 0) begin
         cur = sbq.pop_front();
         act = pick(cur.sel);
         n_vec++;
         if (act !== cur.exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
         end
      end
   end

   task automatic push(input string name, input sel_t sel, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? SP_VAL : 32'h0;
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] a);
      if (rst_n && write_en && rd_addr != 5'd0 && rd_addr == a) return write_data;
      return model[a];
   endfunction

   task automatic expect_all(input string tag);
      push({tag, ".a_rd1"}, A_RD1, model[rs_addr]);
      push({tag, ".a_rd2"}, A_RD2, model[rt_addr]);
      push({tag, ".a_dbg"}, A_DBG, model[dbg_addr]);
      push({tag, ".b_rd1"}, B_RD1, fwd(rs_addr));
      push({tag, ".b_rd2"}, B_RD2, fwd(rt_addr));
      push({tag, ".b_dbg"}, B_DBG, model[dbg_addr]);
   endtask

   // Advance one edge, committing to the model what the edge should commit.
   task automatic cyc();
      @(posedge clk);
      if (rst_n && write_en && rd_addr != 5'd0) model[rd_addr] = write_data;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; write_en = 1'b0; write_data = '0;
      rs_addr = '0; rt_addr = '0; rd_addr = '0; dbg_addr = 5'd29;
      model_reset();
      push("rst_sp_a", A_DBG, 32'h0000_3FFC);
      push("rst_sp_b", B_DBG, 32'h0000_3FFC);
      cyc(); cyc();
      rst_n = 1'b1;

      // Reset-value sweep over all addresses on all ports.
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i); rs_addr = 5'(i); rt_addr = 5'(31 - i);
         push("sweep_dbg", A_DBG, (i == 29) ? 32'h3FFC : 32'h0);
         expect_all("sweep");
         cyc();
      end

      // Write r5: old value before the edge (non-forwarding), new value after.
      write_en = 1'b1; rd_addr = 5'd5; write_data = 32'hDEAD_BEEF;
      rs_addr = 5'd5; rt_addr = 5'd5; dbg_addr = 5'd5;
      push("pre_r5_a1", A_RD1, 32'h0);
      push("pre_r5_a2", A_RD2, 32'h0);
      push("pre_r5_b1", B_RD1, 32'hDEAD_BEEF);
      push("pre_r5_bdbg", B_DBG, 32'h0);
      expect_all("pre_r5");
      cyc();
      write_en = 1'b0;
      push("post_r5_a1", A_RD1, 32'hDEAD_BEEF);
      push("post_r5_a2", A_RD2, 32'hDEAD_BEEF);
      expect_all("post_r5");
      cyc();

      // Write to r0 is discarded and never forwarded.
      write_en = 1'b1; rd_addr = 5'd0; write_data = 32'hFFFF_FFFF;
      rs_addr = 5'd0; rt_addr = 5'd5; dbg_addr = 5'd0;
      push("r0_pend_b1", B_RD1, 32'h0);
      expect_all("r0_pend");
      cyc();
      write_en = 1'b0;
      push("r0_after_a1", A_RD1, 32'h0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i); rs_addr = 5'(i); rt_addr = 5'(i);
         push("r0_sweep", A_DBG, (i == 29) ? 32'h3FFC : (i == 5) ? 32'hDEAD_BEEF : 32'h0);
         expect_all("r0_sweep");
         cyc();
      end

      // Forwarding on rt only; debug never forwards.
      write_en = 1'b1; rd_addr = 5'd7; write_data = 32'h1234;
      rs_addr = 5'd5; rt_addr = 5'd7; dbg_addr = 5'd7;
      push("byp_b2", B_RD2, 32'h1234);
      push("byp_a2", A_RD2, 32'h0);
      push("byp_bdbg", B_DBG, 32'h0);
      push("byp_b1_other", B_RD1, 32'hDEAD_BEEF);
      expect_all("byp");
      cyc();
      write_en = 1'b0;
      push("byp_after_bdbg", B_DBG, 32'h1234);
      expect_all("byp_after");
      cyc();

      // Two writes, then asynchronous reset mid-cycle.
      write_en = 1'b1; rd_addr = 5'd10; write_data = 32'h55;
      cyc();
      rd_addr = 5'd11; write_data = 32'hAA;
      cyc();
      write_en = 1'b0; rs_addr = 5'd10; rt_addr = 5'd11; dbg_addr = 5'd7;
      push("r10", A_RD1, 32'h55);
      push("r11", A_RD2, 32'hAA);
      expect_all("r10_r11");
      cyc();
      #2;
      rst_n = 1'b0; dbg_addr = 5'd29;
      model_reset();
      push("arst_r10_a", A_RD1, 32'h0);
      push("arst_r11_a", A_RD2, 32'h0);
      push("arst_r10_b", B_RD1, 32'h0);
      push("arst_sp", A_DBG, 32'h3FFC);
      expect_all("arst");
      cyc();
      write_en = 1'b1; rd_addr = 5'd12; write_data = 32'h77; dbg_addr = 5'd12;
      cyc();
      push("rst_wr_dbg", A_DBG, 32'h0);
      expect_all("rst_wr");
      cyc();
      rst_n = 1'b1; write_en = 1'b0; rs_addr = 5'd12; rt_addr = 5'd5;
      push("post_rst_r12", A_RD1, 32'h0);
      push("post_rst_r5", A_RD2, 32'h0);
      expect_all("post_rst");
      cyc();

      // First edge after reset release honours a write.
      write_en = 1'b1; rd_addr = 5'd12; write_data = 32'hCAFE_0001;
      cyc();
      write_en = 1'b0;
      push("first_wr_r12", A_RD1, 32'hCAFE_0001);
      expect_all("first_wr");
      cyc();

      @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
